kernel_kcore_write_back_start_ctrl: RTL and testbench



---
 rtl/kernel_kcore_write_back_start_ctrl_if.sv | 31 +++
 rtl/kernel_kcore_write_back_start_ctrl.sv | 69 ++++++
 tb/tb_kernel_kcore_write_back_start_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/kernel_kcore_write_back_start_ctrl_if.sv
// kernel_kcore_write_back_start_ctrl_if: start-FIFO, ap_ctrl_chain and completion signals of the write_back start controller
interface kernel_kcore_write_back_start_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 enable;
    logic                 tok_empty_n;
    logic                 tok_read;
    logic                 ap_start;
    logic                 ap_ready;
    logic                 ap_done;
    logic                 ap_continue;
    logic                 task_done_valid;
    logic                 task_done_ready;
    logic [2:0]           outstanding;
    logic [CNT_WIDTH-1:0] tasks_issued;
    logic [CNT_WIDTH-1:0] tasks_done;
    logic                 idle;
    logic                 protocol_err;

    modport master (
        input  enable, tok_empty_n, ap_ready, ap_done, task_done_ready,
        output tok_read, ap_start, ap_continue, task_done_valid,
               outstanding, tasks_issued, tasks_done, idle, protocol_err
    );

    modport slave (
        output enable, tok_empty_n, ap_ready, ap_done, task_done_ready,
        input  tok_read, ap_start, ap_continue, task_done_valid,
               outstanding, tasks_issued, tasks_done, idle, protocol_err
    );
endinterface

// File: rtl/kernel_kcore_write_back_start_ctrl.sv
// kernel_kcore_write_back_start_ctrl: drains write_back start tokens, drives ap_ctrl_chain and bounds tasks in flight
module kernel_kcore_write_back_start_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_WIDTH       = 32
) (
    input  logic clk,
    input  logic reset_n,
    kernel_kcore_write_back_start_ctrl_if.master bus
);
    typedef enum logic {IDLE, START} state_t;

    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    state_t               state;
    state_t               state_nxt;
    logic                 start_hs;
    logic                 done_hs;
    logic                 err_set;
    logic [2:0]           out_q;
    logic [CNT_WIDTH-1:0] issued_q;
    logic [CNT_WIDTH-1:0] done_q;
    logic                 err_q;

    // state register; reset drops ap_start immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // enable is only looked at in IDLE; START holds until write_back accepts
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = (bus.enable && bus.tok_empty_n && out_q < MAX_OUT) ? START : IDLE;
        else               state_nxt = bus.ap_ready ? IDLE : START;
    end

    // handshake decode: start pops the token, done is passed through with zero latency
    always_comb begin
        bus.ap_start        = state == START;
        start_hs            = state == START && bus.ap_ready;
        bus.tok_read        = start_hs;
        bus.task_done_valid = bus.ap_done && out_q != 3'd0;
        done_hs             = bus.task_done_valid && bus.task_done_ready;
        bus.ap_continue     = done_hs;
        bus.idle            = state == IDLE && out_q == 3'd0 && !bus.tok_empty_n;
        err_set             = (state == IDLE && bus.ap_ready) || (bus.ap_done && out_q == 3'd0) ||
                              (state == START && !bus.tok_empty_n);
    end

    // in-flight count, wrapping task counters and sticky protocol error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            issued_q <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            out_q <= out_q + 3'(start_hs) - 3'(done_hs);
            if (start_hs) issued_q <= issued_q + CNT_WIDTH'(1);
            if (done_hs)  done_q   <= done_q + CNT_WIDTH'(1);
            if (err_set)  err_q    <= 1'b1;
        end
    end

    assign bus.outstanding  = out_q;
    assign bus.tasks_issued = issued_q;
    assign bus.tasks_done   = done_q;
    assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_kernel_kcore_write_back_start_ctrl.sv
// tb_kernel_kcore_write_back_start_ctrl: randomized and directed bench with reference model and handshake scoreboard
module tb_kernel_kcore_write_back_start_ctrl;
    localparam int MAXO = 2;
    localparam int CW   = 4;
    localparam int MOD  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    kernel_kcore_write_back_start_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    kernel_kcore_write_back_start_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master)
    );

    int   tokens = 0;
    logic en = 1'b0, ready_en = 1'b0, force_ready = 1'b0, done_r = 1'b0, tdr = 1'b0;

    assign bus.tok_empty_n     = tokens > 0;
    assign bus.ap_ready        = force_ready | (ready_en & bus.ap_start);
    assign bus.ap_done         = done_r;
    assign bus.enable          = en;
    assign bus.task_done_ready = tdr;

    int checks = 0;
    int failures = 0;
    int sq[$];
    int dq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: task-level bookkeeping of pending start, tasks in flight and totals
    int m_out = 0, m_iss = 0, m_done = 0;
    bit m_start = 0, m_err = 0;

    // per-cycle compare of every output against the model, then advance the model
    always @(negedge clk) begin
        bit ev, ec, er, ei;
        int o;
        if (!reset_n) begin
            m_start = 0; m_out = 0; m_iss = 0; m_done = 0; m_err = 0;
        end
        ev = bus.ap_done && m_out != 0;
        ec = ev && bus.task_done_ready;
        er = m_start && bus.ap_ready;
        ei = !m_start && m_out == 0 && !bus.tok_empty_n;
        chk("ap_start", int'(bus.ap_start), int'(m_start));
        chk("tok_read", int'(bus.tok_read), int'(er));
        chk("task_done_valid", int'(bus.task_done_valid), int'(ev));
        chk("ap_continue", int'(bus.ap_continue), int'(ec));
        chk("idle", int'(bus.idle), int'(ei));
        chk("outstanding", int'(bus.outstanding), m_out);
        chk("tasks_issued", int'(bus.tasks_issued), m_iss);
        chk("tasks_done", int'(bus.tasks_done), m_done);
        chk("protocol_err", int'(bus.protocol_err), int'(m_err));
        if (reset_n) begin
            o = m_out;
            if (er) begin m_iss = (m_iss + 1) % MOD; sq.push_back(m_iss); end
            if (ec) begin m_done = (m_done + 1) % MOD; dq.push_back(m_done); end
            m_out = o + int'(er) - int'(ec);
            if ((!m_start && bus.ap_ready) || (bus.ap_done && o == 0) || (m_start && !bus.tok_empty_n)) m_err = 1;
            m_start = m_start ? !bus.ap_ready : (bus.enable && bus.tok_empty_n && o < MAXO);
        end
    end

    // scoreboard monitor: each observed handshake pops its expected counter value
    always begin
        logic r, c;
        @(posedge clk);
        r = bus.tok_read;
        c = bus.ap_continue;
        #2;
        if (r) chk("sb_issue", int'(bus.tasks_issued), sq.size() == 0 ? -1 : sq.pop_front());
        if (c) chk("sb_done", int'(bus.tasks_done), dq.size() == 0 ? -1 : dq.pop_front());
    end

    task automatic step();
        logic r, c;
        @(posedge clk);
        r = bus.tok_read;
        c = bus.ap_continue;
        #1;
        if (r && tokens > 0) tokens--;
        if (c) done_r = 1'b0;
    endtask

    task automatic do_reset();
        en = 0; ready_en = 0; force_ready = 0; done_r = 0; tdr = 0; tokens = 0;
        #3 reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("reset_idle", int'(bus.idle), 1);

        // single task
        do_reset();
        tokens = 1; en = 1; ready_en = 1;
        repeat (3) step();
        chk("single_outstanding", int'(bus.outstanding), 1);
        chk("single_tokens_popped", tokens, 0);
        done_r = 1; tdr = 1;
        step();
        chk("single_done", int'(bus.tasks_done), 1);
        chk("single_idle", int'(bus.idle), 1);

        // outstanding limit
        do_reset();
        tokens = 5; en = 1; ready_en = 1;
        repeat (8) step();
        chk("limit_outstanding", int'(bus.outstanding), 2);
        chk("limit_issued", int'(bus.tasks_issued), 2);
        chk("limit_tokens_left", tokens, 3);
        done_r = 1; tdr = 1;
        step();
        repeat (6) step();
        chk("limit_issued_after", int'(bus.tasks_issued), 3);
        chk("limit_outstanding_after", int'(bus.outstanding), 2);

        // simultaneous start and done handshakes
        do_reset();
        tokens = 1; en = 1; ready_en = 1;
        repeat (4) step();
        ready_en = 0; tokens = 1;
        repeat (2) step();
        chk("sim_pending_start", int'(bus.ap_start), 1);
        ready_en = 1; done_r = 1; tdr = 1;
        step();
        chk("sim_outstanding", int'(bus.outstanding), 1);
        chk("sim_issued", int'(bus.tasks_issued), 2);
        chk("sim_done", int'(bus.tasks_done), 1);

        // backpressure
        do_reset();
        tokens = 1; en = 1; ready_en = 1;
        repeat (3) step();
        done_r = 1; tdr = 0;
        repeat (10) begin
            step();
            chk("bp_valid", int'(bus.task_done_valid), 1);
            chk("bp_continue", int'(bus.ap_continue), 0);
        end
        chk("bp_frozen", int'(bus.tasks_done), 0);
        tdr = 1;
        step();
        tdr = 0;
        step();
        chk("bp_one_done", int'(bus.tasks_done), 1);
        chk("bp_outstanding", int'(bus.outstanding), 0);

        // counter wrap with 17 completions
        do_reset();
        en = 1; ready_en = 1; tdr = 1;
        repeat (17) begin
            tokens++;
            repeat (2) step();
            done_r = 1;
            step();
        end
        chk("wrap_done", int'(bus.tasks_done), 1);
        chk("wrap_issued", int'(bus.tasks_issued), 1);

        // randomized traffic with a legal write_back
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0 && tokens < 6) tokens++;
            en = $urandom_range(9) < 8;
            ready_en = $urandom_range(1);
            tdr = $urandom_range(2) != 0;
            if (!done_r && m_out > 0 && $urandom_range(2) == 0) done_r = 1;
            step();
        end

        // protocol errors
        do_reset();
        done_r = 1;
        step();
        done_r = 0;
        step();
        chk("err_after_done", int'(bus.protocol_err), 1);
        force_ready = 1;
        step();
        force_ready = 0;
        repeat (2) step();
        chk("err_sticky", int'(bus.protocol_err), 1);
        chk("err_no_issue", int'(bus.tasks_issued), 0);
        chk("err_no_done", int'(bus.tasks_done), 0);

        // reset in the middle of a pending start
        do_reset();
        tokens = 1; en = 1; ready_en = 1;
        repeat (3) step();
        ready_en = 0; tokens = 1;
        repeat (2) step();
        chk("pre_reset_ap_start", int'(bus.ap_start), 1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_ap_start", int'(bus.ap_start), 0);
        en = 0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("post_reset_outstanding", int'(bus.outstanding), 0);
        chk("post_reset_issued", int'(bus.tasks_issued), 0);
        chk("post_reset_done", int'(bus.tasks_done), 0);
        chk("post_reset_err", int'(bus.protocol_err), 0);

        repeat (2) step();
        chk("sb_issue_drained", sq.size(), 0);
        chk("sb_done_drained", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
